// File: rtl/hazard_unit_pkg.sv
// Shared types for the ID-stage hazard logic: hazard classes, rs2 usage,
// next-PC source and the scoreboard drain state.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    HazardNone,
    HazardDecode,
    HazardExecute,
    HazardException
  } hazard_t;

  typedef enum logic {
    Rs2Unused,
    Rs2Used
  } rs_used_t;

  typedef enum logic [1:0] {
    PcPlus4,
    PcBranch,
    PcJump,
    PcTrap
  } pc_src_t;

  typedef enum logic {
    RUN,
    DRAIN
  } scoreboard_state_t;

  localparam int unsigned RegNumDefault     = 32;
  localparam int unsigned MaxPendingDefault = 4;

endpackage

// File: rtl/hazard_scoreboard_unit_reg_scoreboard.sv
// Per-register pending-write tracker for long-latency ops, with an
// outstanding-op counter and a sticky error for unexpected retires.
module reg_scoreboard
  import hazard_unit_pkg::*;
#(
  parameter int unsigned RegNum       = RegNumDefault,
  parameter int unsigned RegAddrWidth = $clog2(RegNum),
  parameter int unsigned MaxPending   = MaxPendingDefault,
  parameter int unsigned CntWidth     = $clog2(MaxPending + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_set,
  input  logic [RegAddrWidth-1:0] i_set_rd,
  input  logic                    i_wb_valid,
  input  logic [RegAddrWidth-1:0] i_wb_rd,
  input  logic [RegAddrWidth-1:0] i_rs1,
  input  logic [RegAddrWidth-1:0] i_rs2,
  input  logic [RegAddrWidth-1:0] i_rd,
  output logic                    o_pend_rs1,
  output logic                    o_pend_rs2,
  output logic                    o_pend_rd,
  output logic                    o_full,
  output logic                    o_busy,
  output logic [CntWidth-1:0]     o_count,
  output logic                    o_error
);

  logic [RegNum-1:0]   r_pending;
  logic [CntWidth-1:0] r_count;
  logic                r_error;
  logic                w_clr;
  logic                w_bad_wb;

  always_comb begin
    w_clr    = i_wb_valid && (i_wb_rd != '0) && r_pending[i_wb_rd];
    w_bad_wb = i_wb_valid && (i_wb_rd != '0) && !r_pending[i_wb_rd];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_count   <= '0;
      r_error   <= 1'b0;
    end else begin
      if (i_set) r_pending[i_set_rd] <= 1'b1;
      if (w_clr) r_pending[i_wb_rd]  <= 1'b0;
      case ({i_set, w_clr})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: ;
      endcase
      if (w_bad_wb) r_error <= 1'b1;
    end
  end

  // A WAW stall keeps a pending register from being re-issued, so the
  // same register can never be set and cleared in one cycle.
  a_no_set_clr_same_reg: assert property (
    @(posedge i_clk) disable iff (i_rst)
    !(i_set && w_clr && (i_set_rd == i_wb_rd))
  );

  always_comb begin
    o_pend_rs1 = (i_rs1 != '0) && r_pending[i_rs1];
    o_pend_rs2 = (i_rs2 != '0) && r_pending[i_rs2];
    o_pend_rd  = (i_rd  != '0) && r_pending[i_rd];
    o_full     = (r_count == CntWidth'(MaxPending));
    o_busy     = (r_count != '0);
    o_count    = r_count;
    o_error    = r_error;
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: base load-use/decode stalls, long-op scoreboard
// stalls, and a drain FSM that delays exception flushes until long ops retire.
module hazard_scoreboard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned RegNum       = RegNumDefault,
  parameter int unsigned RegAddrWidth = $clog2(RegNum),
  parameter int unsigned MaxPending   = MaxPendingDefault,
  parameter int unsigned CntWidth     = $clog2(MaxPending + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  hazard_t                 hazard_type,
  input  rs_used_t                rs_used,
  input  pc_src_t                 pc_src,
  input  logic [RegAddrWidth-1:0] rs1_id,
  input  logic [RegAddrWidth-1:0] rs2_id,
  input  logic [RegAddrWidth-1:0] rd_id,
  input  logic                    reg_we_id,
  input  logic                    long_id,
  input  logic                    store_id,
  input  logic                    issue_id,
  input  logic [RegAddrWidth-1:0] rd_ex,
  input  logic [RegAddrWidth-1:0] rd_mem,
  input  logic                    reg_we_ex,
  input  logic                    reg_we_mem,
  input  logic                    mem_rd_en_ex,
  input  logic                    mem_rd_en_mem,
  input  logic                    rd_complete_ex,
  input  logic                    wb_long_valid,
  input  logic [RegAddrWidth-1:0] wb_long_rd,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    flush_id,
  output logic                    flush_ex,
  output logic                    busy,
  output logic [CntWidth-1:0]     pending_count,
  output logic                    sb_error
);

  scoreboard_state_t r_state;
  scoreboard_state_t w_state_next;

  logic w_pend_rs1, w_pend_rs2, w_pend_rd, w_full, w_busy;
  logic w_rs2_used, w_ex_match, w_mem_match;
  logic w_decode_stall, w_exec_stall, w_sb_stall;
  logic w_stall, w_fsm_flush, w_set;

  reg_scoreboard #(
    .RegNum      (RegNum),
    .RegAddrWidth(RegAddrWidth),
    .MaxPending  (MaxPending),
    .CntWidth    (CntWidth)
  ) u_reg_scoreboard (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_set     (w_set),
    .i_set_rd  (rd_id),
    .i_wb_valid(wb_long_valid),
    .i_wb_rd   (wb_long_rd),
    .i_rs1     (rs1_id),
    .i_rs2     (rs2_id),
    .i_rd      (rd_id),
    .o_pend_rs1(w_pend_rs1),
    .o_pend_rs2(w_pend_rs2),
    .o_pend_rd (w_pend_rd),
    .o_full    (w_full),
    .o_busy    (w_busy),
    .o_count   (pending_count),
    .o_error   (sb_error)
  );

  always_comb begin
    w_rs2_used  = (rs_used == Rs2Used);
    w_ex_match  = (rd_ex != '0) &&
                  ((rs1_id == rd_ex) || (w_rs2_used && (rs2_id == rd_ex)));
    w_mem_match = (rd_mem != '0) &&
                  ((rs1_id == rd_mem) || (w_rs2_used && (rs2_id == rd_mem)));

    w_decode_stall = (hazard_type == HazardDecode) &&
                     ((w_ex_match && reg_we_ex && !rd_complete_ex) ||
                      (w_mem_match && reg_we_mem && mem_rd_en_mem));
    w_exec_stall   = (hazard_type == HazardExecute) && mem_rd_en_ex && (rd_ex != '0) &&
                     ((rs1_id == rd_ex) ||
                      (w_rs2_used && !store_id && (rs2_id == rd_ex)));
    w_sb_stall     = issue_id &&
                     (w_pend_rs1 || (w_rs2_used && w_pend_rs2) ||
                      (reg_we_id && w_pend_rd) || (long_id && w_full));
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_fsm_flush  = 1'b0;
    case (r_state)
      RUN: begin
        if (hazard_type == HazardException) begin
          if (!w_busy) begin
            w_fsm_flush = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_state_next = DRAIN;
          end
        end else if (w_sb_stall || w_decode_stall || w_exec_stall) begin
          w_stall = 1'b1;
        end
      end
      DRAIN: begin
        if (!w_busy) begin
          w_fsm_flush  = 1'b1;
          w_state_next = RUN;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    stall_if = w_stall;
    stall_id = w_stall;
    flush_ex = w_stall || w_fsm_flush;
    flush_id = w_fsm_flush || (pc_src != PcPlus4);
    busy     = w_busy;
    // Only an instruction that actually leaves ID in RUN claims its rd.
    w_set    = issue_id && long_id && reg_we_id && (rd_id != '0) &&
               !stall_id && !flush_id && (r_state == RUN);
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed scenarios plus
// randomized traffic against a behavioural scoreboard model.
module tb_hazard_scoreboard_unit;
  import hazard_unit_pkg::*;

  localparam int NREG = 32;
  localparam int MAXP = 4;

  logic       clock = 1'b0;
  logic       reset;
  hazard_t    hazard_type;
  rs_used_t   rs_used;
  pc_src_t    pc_src;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_ex, rd_mem, wb_long_rd;
  logic       reg_we_id, long_id, store_id, issue_id;
  logic       reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem, rd_complete_ex;
  logic       wb_long_valid;
  logic       stall_if, stall_id, flush_id, flush_ex, busy, sb_error;
  logic [2:0] pending_count;
  logic [8:0] obs;

  int errors = 0;
  int checks = 0;

  bit         m_pend[NREG];
  bit         m_drain;
  bit         m_err;
  bit         e_stall, e_fid, e_fex, e_set;
  logic [8:0] e_vec;

  always #5 clock = ~clock;

  assign obs = {stall_if, stall_id, flush_id, flush_ex, busy, sb_error, pending_count};

  hazard_scoreboard_unit #(.RegNum(32), .MaxPending(4)) dut (
    .clock(clock), .reset(reset), .hazard_type(hazard_type), .rs_used(rs_used),
    .pc_src(pc_src), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .reg_we_id(reg_we_id), .long_id(long_id), .store_id(store_id), .issue_id(issue_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem),
    .mem_rd_en_ex(mem_rd_en_ex), .mem_rd_en_mem(mem_rd_en_mem),
    .rd_complete_ex(rd_complete_ex), .wb_long_valid(wb_long_valid),
    .wb_long_rd(wb_long_rd), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .busy(busy),
    .pending_count(pending_count), .sb_error(sb_error)
  );

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < NREG; k++) c += int'(m_pend[k]);
    return c;
  endfunction

  function automatic bit reads(logic [4:0] r, bit use2);
    return (r != 0) && ((rs1_id == r) || (use2 && (rs2_id == r)));
  endfunction

  task automatic model_eval();
    int cnt = m_count();
    bit fl = 0, st = 0, r2, sb, dec, exe;
    r2 = (rs_used == Rs2Used);
    if (m_drain || hazard_type == HazardException) begin
      if (cnt == 0) fl = 1; else st = 1;
    end else begin
      sb  = issue_id && ((rs1_id != 0 && m_pend[rs1_id]) ||
                         (r2 && rs2_id != 0 && m_pend[rs2_id]) ||
                         (reg_we_id && rd_id != 0 && m_pend[rd_id]) ||
                         (long_id && cnt == MAXP));
      dec = (hazard_type == HazardDecode) &&
            ((reg_we_ex && !rd_complete_ex && reads(rd_ex, r2)) ||
             (reg_we_mem && mem_rd_en_mem && reads(rd_mem, r2)));
      exe = (hazard_type == HazardExecute) && mem_rd_en_ex && reads(rd_ex, r2 && !store_id);
      st  = sb || dec || exe;
    end
    e_stall = st;
    e_fid   = fl || (pc_src != PcPlus4);
    e_fex   = st || fl;
    e_set   = !m_drain && issue_id && long_id && reg_we_id && rd_id != 0 && !st && !e_fid;
    e_vec   = {e_stall, e_stall, e_fid, e_fex, cnt != 0, m_err, 3'(cnt)};
  endtask

  task automatic model_tick();
    int cnt = m_count();
    bit exc = !m_drain && (hazard_type == HazardException);
    if (reset) begin
      for (int k = 0; k < NREG; k++) m_pend[k] = 0;
      m_drain = 0;
      m_err   = 0;
    end else begin
      if (wb_long_valid && wb_long_rd != 0) begin
        if (m_pend[wb_long_rd]) m_pend[wb_long_rd] = 0;
        else m_err = 1;
      end
      if (e_set) m_pend[rd_id] = 1;
      if (m_drain && cnt == 0) m_drain = 0;
      else if (exc && cnt != 0) m_drain = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_eval();
    model_tick();
    #1;
  endtask

  task automatic idle();
    hazard_type = HazardNone; rs_used = Rs2Unused; pc_src = PcPlus4;
    rs1_id = 0; rs2_id = 0; rd_id = 0; rd_ex = 0; rd_mem = 0; wb_long_rd = 0;
    reg_we_id = 0; long_id = 0; store_id = 0; issue_id = 0;
    reg_we_ex = 0; reg_we_mem = 0; mem_rd_en_ex = 0; mem_rd_en_mem = 0;
    rd_complete_ex = 0; wb_long_valid = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    idle();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic issue_long(logic [4:0] rd);
    idle();
    issue_id = 1; long_id = 1; reg_we_id = 1; rd_id = rd;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    model_eval();
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=%b", obs, 9'b0);
    end
    checks++;
    if (obs !== e_vec) begin
      errors++; $display("FAIL reset_model got=%b want=%b", obs, e_vec);
    end
    tick();
  endtask

  task automatic test_load_use();
    bit exp_st[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      idle();
      hazard_type = HazardExecute; issue_id = 1;
      mem_rd_en_ex = 1; reg_we_ex = 1; rd_ex = 5;
      rs1_id   = (i == 0) ? 5'd5 : 5'd3;
      rs2_id   = 5'd5;
      rs_used  = (i == 0) ? Rs2Unused : Rs2Used;
      store_id = (i == 1);
      @(negedge clock);
      model_eval();
      checks++;
      if (obs !== e_vec) begin
        errors++; $display("FAIL load_use_model i=%0d got=%b want=%b", i, obs, e_vec);
      end
      checks++;
      if ({stall_if, stall_id, flush_ex} !== {3{exp_st[i]}}) begin
        errors++;
        $display("FAIL load_use_stall i=%0d got=%b want=%b", i,
                 {stall_if, stall_id, flush_ex}, {3{exp_st[i]}});
      end
      tick();
    end
  endtask

  task automatic test_long_raw();
    bit         exp_st[6]  = '{0, 1, 1, 1, 1, 0};
    logic [2:0] exp_cnt[6] = '{0, 1, 1, 1, 1, 0};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) issue_long(5'd7);
      else begin
        idle();
        issue_id = 1; rs1_id = 2; rs2_id = 7; rs_used = Rs2Used;
        wb_long_valid = (i == 4); wb_long_rd = 7;
      end
      @(negedge clock);
      model_eval();
      checks++;
      if (obs !== e_vec) begin
        errors++; $display("FAIL long_raw_model i=%0d got=%b want=%b", i, obs, e_vec);
      end
      checks++;
      if (stall_id !== exp_st[i] || pending_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL long_raw i=%0d stall=%b cnt=%0d want stall=%b cnt=%0d", i,
                 stall_id, pending_count, exp_st[i], exp_cnt[i]);
      end
      tick();
    end
  endtask

  task automatic test_full();
    bit         exp_st[8]  = '{0, 0, 0, 0, 1, 1, 0, 0};
    logic [2:0] exp_cnt[8] = '{0, 1, 2, 3, 4, 4, 3, 4};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) issue_long(5'(i + 1));
      else if (i < 7) begin
        issue_long(5'd5);
        wb_long_valid = (i == 5); wb_long_rd = 1;
      end else idle();
      @(negedge clock);
      model_eval();
      checks++;
      if (obs !== e_vec) begin
        errors++; $display("FAIL full_model i=%0d got=%b want=%b", i, obs, e_vec);
      end
      checks++;
      if (stall_id !== exp_st[i] || pending_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL full i=%0d stall=%b cnt=%0d want stall=%b cnt=%0d", i,
                 stall_id, pending_count, exp_st[i], exp_cnt[i]);
      end
      tick();
    end
  endtask

  task automatic test_exception_drain();
    bit         exp_st[9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit         exp_fid[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit         exp_fex[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [2:0] exp_cnt[9] = '{2, 2, 2, 2, 1, 1, 1, 0, 0};
    apply_reset();
    issue_long(5'd10); tick();
    issue_long(5'd11); tick();
    for (int i = 0; i < 9; i++) begin
      if (i == 2) issue_long(5'd12);
      else idle();
      if (i <= 6) hazard_type = HazardException;
      wb_long_valid = (i == 3) || (i == 6);
      wb_long_rd    = (i == 3) ? 5'd10 : 5'd11;
      @(negedge clock);
      model_eval();
      checks++;
      if (obs !== e_vec) begin
        errors++; $display("FAIL drain_model i=%0d got=%b want=%b", i, obs, e_vec);
      end
      checks++;
      if ({stall_id, flush_id, flush_ex} !== {exp_st[i], exp_fid[i], exp_fex[i]} ||
          pending_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL drain i=%0d st/fid/fex=%b cnt=%0d want %b cnt=%0d", i,
                 {stall_id, flush_id, flush_ex}, pending_count,
                 {exp_st[i], exp_fid[i], exp_fex[i]}, exp_cnt[i]);
      end
      tick();
    end
  endtask

  task automatic test_error_x0();
    bit exp_err[5] = '{0, 0, 0, 1, 1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) issue_long(5'd0);
      else idle();
      wb_long_valid = (i == 1) || (i == 2);
      wb_long_rd    = (i == 2) ? 5'd9 : 5'd0;
      @(negedge clock);
      model_eval();
      checks++;
      if (obs !== e_vec) begin
        errors++; $display("FAIL err_x0_model i=%0d got=%b want=%b", i, obs, e_vec);
      end
      checks++;
      if (sb_error !== exp_err[i] || pending_count !== 3'd0) begin
        errors++;
        $display("FAIL err_x0 i=%0d err=%b cnt=%0d want err=%b cnt=0", i,
                 sb_error, pending_count, exp_err[i]);
      end
      tick();
    end
    apply_reset();
    @(negedge clock);
    checks++;
    if (sb_error !== 1'b0) begin
      errors++; $display("FAIL err_cleared got=%b want=0", sb_error);
    end
  endtask

  task automatic test_reset_in_drain();
    apply_reset();
    issue_long(5'd3); tick();
    issue_long(5'd4); tick();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) hazard_type = HazardException;
      reset         = (i == 2);
      wb_long_valid = (i == 4); wb_long_rd = 3;
      @(negedge clock);
      model_eval();
      checks++;
      if (obs !== e_vec) begin
        errors++; $display("FAIL rst_drain_model i=%0d got=%b want=%b", i, obs, e_vec);
      end
      if (i == 3) begin
        checks++;
        if (obs !== 9'b0) begin
          errors++; $display("FAIL rst_drain_clear got=%b want=%b", obs, 9'b0);
        end
      end
      if (i == 5) begin
        checks++;
        if (sb_error !== 1'b1) begin
          errors++; $display("FAIL rst_drain_late_retire err=%b want=1", sb_error);
        end
      end
      tick();
    end
    reset = 0;
  endtask

  task automatic test_random();
    int q[$];
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset          = ($urandom_range(0, 299) == 0);
      hazard_type    = ($urandom_range(0, 23) == 0) ? HazardException
                                                    : hazard_t'(2'($urandom_range(0, 2)));
      rs_used        = rs_used_t'(1'($urandom_range(0, 1)));
      pc_src         = ($urandom_range(0, 7) == 0) ? pc_src_t'(2'($urandom_range(1, 3))) : PcPlus4;
      rs1_id         = 5'($urandom_range(0, 7));
      rs2_id         = 5'($urandom_range(0, 7));
      rd_id          = 5'($urandom_range(0, 7));
      rd_ex          = 5'($urandom_range(0, 7));
      rd_mem         = 5'($urandom_range(0, 7));
      issue_id       = ($urandom_range(0, 3) != 0);
      long_id        = ($urandom_range(0, 2) == 0);
      reg_we_id      = ($urandom_range(0, 3) != 0);
      store_id       = 1'($urandom_range(0, 1));
      reg_we_ex      = 1'($urandom_range(0, 1));
      reg_we_mem     = 1'($urandom_range(0, 1));
      mem_rd_en_ex   = 1'($urandom_range(0, 1));
      mem_rd_en_mem  = 1'($urandom_range(0, 1));
      rd_complete_ex = 1'($urandom_range(0, 1));
      wb_long_valid  = ($urandom_range(0, 2) == 0);
      q.delete();
      for (int k = 1; k < 8; k++) if (m_pend[k]) q.push_back(k);
      if (q.size() != 0 && $urandom_range(0, 9) != 0)
        wb_long_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        wb_long_rd = 5'($urandom_range(0, 15));
      @(negedge clock);
      model_eval();
      checks++;
      if (obs !== e_vec) begin
        errors++; $display("FAIL rand cyc=%0d got=%b want=%b", n, obs, e_vec);
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_load_use();
    test_long_raw();
    test_full();
    test_exception_drain();
    test_error_x0();
    test_reset_in_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
